rf_scoreboard: RTL
==================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1.
REQ-002 Parameter NREG, default 32: architectural register count; address width 5.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 issue_valid  in  1  decode stage presents an instruction.
REQ-006 issue_rs1, issue_rs2  in  5 each  source register addresses.
REQ-007 issue_rd  in  5  destination register address.
REQ-008 issue_wen  in  1  instruction will write issue_rd.
REQ-009 issue_ready  out  1  instruction may be accepted this cycle.
REQ-010 wb_valid  in  1  writeback stage is writing the register file this cycle.
REQ-011 wb_rd  in  5  writeback destination address.
REQ-012 flush  in  1  pipeline flush; discards all pending writes.
REQ-013 drain_req  in  1  request to quiesce the register file.
REQ-014 resume  in  1  leave HALT.
REQ-015 halted  out  1  no writes pending; issue blocked.
REQ-016 busy_vec  out  32  bit i = register i has a nonzero pending count.
REQ-017 underflow_err  out  1  sticky: writeback arrived for a register with zero pending count.

Function
REQ-018 Issue accepted when issue_valid && issue_ready; the counter update takes effect on the next edge.
REQ-019 issue_ready = (state==RUN) && !hz, where hz = rs1 pending || rs2 pending || (issue_wen && rd!=0 && cnt[rd] saturated); register 0 is never pending.
REQ-020 issue_ready uses registered counters only; a same-cycle writeback does not clear a hazard (no bypass).
REQ-021 Accepted issue with issue_wen && rd!=0: cnt[rd] += 1. Writes with rd==0 are never tracked.
REQ-022 wb_valid with wb_rd!=0 and cnt[wb_rd]>0: cnt[wb_rd] -= 1. If cnt==0: no change; set underflow_err.
REQ-023 Accepted issue and writeback to the same register in the same cycle: counter unchanged.
REQ-024 flush clears all counters next edge and overrides same-cycle issue and writeback; it does not change the FSM state; a later writeback to a cleared register sets underflow_err.
REQ-025 FSM states RUN, DRAIN, HALT. RUN->DRAIN on drain_req. DRAIN->HALT when all counters are zero (including the cycle flush takes effect). HALT->RUN on resume. resume is ignored outside HALT. drain_req is ignored outside RUN.
REQ-026 halted = (state==HALT), registered.
REQ-027 busy_vec and underflow_err are registered; busy_vec reflects counters after the edge.
REQ-028 underflow_err is cleared only by reset.

Reset
REQ-029 On rst low, asynchronously: all counters 0, state RUN, halted 0, busy_vec 0, underflow_err 0; issue_ready is then 1 for any operands.
REQ-030 Reset mid-operation discards pending counts with no error flagged.

Structure
REQ-031 Shared package rf_sched_pkg holds the FSM state enum, NREG, the register address width and the default CNT_W.
REQ-032 One sub-module, sb_cnt_cell: one saturating up/down counter with clear, inc, dec and an underflow flag; instantiated NREG-1 times (indices 1..31).

Verification
REQ-033 Issue rd=5 (wen) -> busy_vec[5]=1 next cycle; issue rs1=5 -> issue_ready=0; wb_rd=5 -> ready=1 the cycle after.
REQ-034 Three issues to rd=7 with CNT_W=2 -> fourth issue to rd=7 gets ready=0; one wb to 7 -> ready=1.
REQ-035 Same-cycle issue rd=3 and wb rd=3 with cnt[3]=1 -> cnt stays 1, busy_vec[3]=1.
REQ-036 Pending on r4,r9; drain_req -> ready=0, state DRAIN; wbs to 4 and 9 -> halted=1 the next cycle; resume -> RUN, ready=1.
REQ-037 flush with r2 pending, then wb_rd=2 -> busy_vec=0, underflow_err=1 sticky; rst low mid-sequence -> all outputs at reset values.
REQ-038 Issue rd=0 and rs1=0 repeatedly -> busy_vec stays 0, ready stays 1.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file scoreboard: sizes, counter width
// default and the drain/halt FSM state encoding.
package rf_sched_pkg;

  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned AW        = 5;
  localparam int unsigned DEF_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sb_cnt_cell.sv
// One pending-write counter: saturating up/down count with synchronous clear
// and a combinational underflow strobe for a decrement at zero.
module sb_cnt_cell
  import rf_sched_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic busy_next,
  output logic sat,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  assign busy = (cnt != '0);
  assign sat  = (cnt == '1);

  // A simultaneous inc and dec cancel; clear wins over both and masks underflow.
  always_comb begin
    cnt_d     = cnt;
    underflow = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else begin
      if (dec && (cnt == '0)) underflow = 1'b1;
      if (inc && !dec && !sat)
        cnt_d = cnt + 1'b1;
      else if (dec && !inc && (cnt != '0))
        cnt_d = cnt - 1'b1;
    end
  end

  assign busy_next = (cnt_d != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_d;
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: tracks in-flight writes per register,
// blocks hazardous issue, and supports drain-to-halt quiescing.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned NREG  = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wen,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  input  logic            drain_req,
  input  logic            resume,
  output logic            halted,
  output logic [NREG-1:0] busy_vec,
  output logic            underflow_err
);

  sched_state_t    state, state_d;
  logic [NREG-1:0] busy, busy_next, sat, uf, inc, dec;
  logic            accept, hz;

  assign accept = issue_valid && issue_ready;

  // Register 0 is never tracked, so its slot is tied off.
  assign busy[0]      = 1'b0;
  assign busy_next[0] = 1'b0;
  assign sat[0]       = 1'b0;
  assign uf[0]        = 1'b0;
  assign inc[0]       = 1'b0;
  assign dec[0]       = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cell
    assign inc[i] = accept && issue_wen && (issue_rd == AW'(i));
    assign dec[i] = wb_valid && (wb_rd == AW'(i));

    sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .inc       (inc[i]),
      .dec       (dec[i]),
      .busy      (busy[i]),
      .busy_next (busy_next[i]),
      .sat       (sat[i]),
      .underflow (uf[i])
    );
  end

  // Hazard looks only at registered counts; a same-cycle writeback is not bypassed.
  assign hz = busy[issue_rs1] || busy[issue_rs2] ||
              (issue_wen && (issue_rd != '0) && sat[issue_rd]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_d;
      halted <= (state_d == ST_HALT);
    end
  end

  // DRAIN completes on the edge that leaves every counter at zero.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_RUN:   if (drain_req)   state_d = ST_DRAIN;
      ST_DRAIN: if (~|busy_next) state_d = ST_HALT;
      ST_HALT:  if (resume)      state_d = ST_RUN;
      default:                   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    issue_ready = (state == ST_RUN) && !hz;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec      <= '0;
      underflow_err <= 1'b0;
    end else begin
      busy_vec      <= busy_next;
      underflow_err <= underflow_err || (|uf);
    end
  end

endmodule
